// File: rtl/lathe_seq_pkg.sv
// Shared constants for the lathe cycle sequencer: state encodings,
// fault codes and the timer-width helper.
package lathe_seq_pkg;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_SPINUP   = 3'd1;
    localparam logic [2:0] ST_FEED     = 3'd2;
    localparam logic [2:0] ST_DWELL    = 3'd3;
    localparam logic [2:0] ST_RETRACT  = 3'd4;
    localparam logic [2:0] ST_SPINDOWN = 3'd5;
    localparam logic [2:0] ST_FAULT    = 3'd6;

    localparam logic [2:0] FC_NONE     = 3'd0;
    localparam logic [2:0] FC_NOT_HOME = 3'd1;
    localparam logic [2:0] FC_FEED_TO  = 3'd2;
    localparam logic [2:0] FC_RETR_TO  = 3'd3;
    localparam logic [2:0] FC_ESTOP    = 3'd4;

    // Timer width: enough bits for the longest phase plus one headroom bit.
    function automatic int calc_cnt_w(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/lathe_cycle_sequencer_timer.sv
// Shared phase countdown timer. Reloaded on every state entry, counts down
// on enabled cycles; expiry is "value 1 on an enabled cycle", so a phase
// loaded with N lasts exactly N enabled cycles.
module cycle_timer
    import lathe_seq_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_ena,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    output logic             o_expire
);

    logic [CNT_W-1:0] r_cnt;

    // Load has priority; otherwise count down while enabled, parking at zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_ena && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_expire = i_ena && (r_cnt == CNT_W'(1));

endmodule

// File: rtl/lathe_cycle_sequencer.sv
// Machining-cycle controller: spin-up, feed to limit, dwell, retract home,
// spin-down, with latched faults on e-stop, not-home and limit timeouts.
module lathe_cycle_sequencer
    import lathe_seq_pkg::*;
#(
    parameter int SETTLE_CYCLES  = 20,
    parameter int DWELL_CYCLES   = 10,
    parameter int TIMEOUT_CYCLES = 100,
    parameter int CNT_W          = calc_cnt_w(SETTLE_CYCLES, DWELL_CYCLES, TIMEOUT_CYCLES)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_ena,
    input  logic       i_start,
    input  logic       i_stop,
    input  logic       i_estop,
    input  logic       i_fault_clr,
    input  logic       i_lim_fwd,
    input  logic       i_lim_home,
    output logic       o_spindle_on,
    output logic       o_coolant_on,
    output logic       o_feed_fwd,
    output logic       o_feed_rev,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_fault,
    output logic [2:0] o_fault_code,
    output logic [2:0] o_state
);

    localparam logic [CNT_W-1:0] LV_SETTLE  = CNT_W'(SETTLE_CYCLES);
    localparam logic [CNT_W-1:0] LV_DWELL   = CNT_W'(DWELL_CYCLES);
    localparam logic [CNT_W-1:0] LV_TIMEOUT = CNT_W'(TIMEOUT_CYCLES);

    logic [2:0]       r_state;
    logic [2:0]       r_fcode;
    logic             r_abort;
    logic             r_start_q;
    logic             r_done;

    logic [2:0]       w_nxt;
    logic [2:0]       w_fc_nxt;
    logic             w_load;
    logic [CNT_W-1:0] w_load_val;
    logic             w_abort_set;
    logic             w_abort_clr;
    logic             w_done;
    logic             w_expire;
    logic             w_start_edge;
    logic             w_spin_st;

    cycle_timer #(.CNT_W(CNT_W)) u_timer (
        .clk        (clk),
        .reset      (reset),
        .i_ena      (i_ena),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .o_expire   (w_expire)
    );

    assign w_start_edge = i_start && !r_start_q;

    // Next-state decode: estop > stop > limit switch > timer expiry.
    always_comb begin
        w_nxt       = r_state;
        w_fc_nxt    = r_fcode;
        w_load      = 1'b0;
        w_load_val  = '0;
        w_abort_set = 1'b0;
        w_abort_clr = 1'b0;
        w_done      = 1'b0;
        if (i_estop) begin
            // Acts even with the clock-enable low.
            w_nxt    = ST_FAULT;
            w_fc_nxt = FC_ESTOP;
            w_load   = 1'b1;
        end else if (i_ena) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start_edge) begin
                        w_load = 1'b1;
                        if (i_lim_home) begin
                            w_nxt      = ST_SPINUP;
                            w_load_val = LV_SETTLE;
                        end else begin
                            w_nxt    = ST_FAULT;
                            w_fc_nxt = FC_NOT_HOME;
                        end
                    end
                end
                ST_SPINUP, ST_FEED, ST_DWELL: begin
                    if (i_stop) begin
                        w_abort_set = 1'b1;
                        w_nxt       = ST_RETRACT;
                        w_load      = 1'b1;
                        w_load_val  = LV_TIMEOUT;
                    end else if (r_state == ST_FEED) begin
                        if (i_lim_fwd) begin
                            w_nxt      = ST_DWELL;
                            w_load     = 1'b1;
                            w_load_val = LV_DWELL;
                        end else if (w_expire) begin
                            w_nxt    = ST_FAULT;
                            w_fc_nxt = FC_FEED_TO;
                            w_load   = 1'b1;
                        end
                    end else if (w_expire) begin
                        w_nxt      = (r_state == ST_SPINUP) ? ST_FEED : ST_RETRACT;
                        w_load     = 1'b1;
                        w_load_val = LV_TIMEOUT;
                    end
                end
                ST_RETRACT: begin
                    if (i_lim_home) begin
                        w_nxt      = ST_SPINDOWN;
                        w_load     = 1'b1;
                        w_load_val = LV_SETTLE;
                    end else if (w_expire) begin
                        w_nxt    = ST_FAULT;
                        w_fc_nxt = FC_RETR_TO;
                        w_load   = 1'b1;
                    end
                end
                ST_SPINDOWN: begin
                    if (w_expire) begin
                        w_nxt       = ST_IDLE;
                        w_load      = 1'b1;
                        w_done      = !r_abort;
                        w_abort_clr = 1'b1;
                    end
                end
                ST_FAULT: begin
                    // Clearing a fault also drops a stale abort so the next
                    // cycle can report completion normally.
                    if (i_fault_clr) begin
                        w_nxt       = ST_IDLE;
                        w_fc_nxt    = FC_NONE;
                        w_load      = 1'b1;
                        w_abort_clr = 1'b1;
                    end
                end
                default: begin
                    w_nxt  = ST_IDLE;
                    w_load = 1'b1;
                end
            endcase
        end
    end

    // State, fault code, abort flag, done pulse and start-edge history.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_fcode   <= FC_NONE;
            r_abort   <= 1'b0;
            r_start_q <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state <= w_nxt;
            r_fcode <= w_fc_nxt;
            r_done  <= w_done;
            if (w_abort_clr)      r_abort <= 1'b0;
            else if (w_abort_set) r_abort <= 1'b1;
            if (i_ena)            r_start_q <= i_start;
        end
    end

    // Moore decode; motor contactors also drop immediately on e-stop.
    assign w_spin_st    = (r_state == ST_SPINUP) || (r_state == ST_FEED) ||
                          (r_state == ST_DWELL)  || (r_state == ST_RETRACT);
    assign o_spindle_on = w_spin_st && !i_estop;
    assign o_coolant_on = w_spin_st || (r_state == ST_SPINDOWN);
    assign o_feed_fwd   = (r_state == ST_FEED)    && !i_estop;
    assign o_feed_rev   = (r_state == ST_RETRACT) && !i_estop;
    assign o_busy       = (r_state != ST_IDLE) && (r_state != ST_FAULT);
    assign o_done       = r_done;
    assign o_fault      = (r_state == ST_FAULT);
    assign o_fault_code = r_fcode;
    assign o_state      = r_state;

endmodule

// File: tb/tb_lathe_cycle_sequencer.sv
// Randomized bench for lathe_cycle_sequencer: a phase/elapsed-time model
// predicts every output each cycle into a queue; a monitor on the falling
// edge pops and compares.
module tb_lathe_cycle_sequencer;

    localparam int SETTLE = 4;
    localparam int DWELL  = 3;
    localparam int TMO    = 16;
    localparam int NCYC   = 6000;

    // phase numbers follow the published state encodings
    localparam int P_IDLE = 0, P_SPINUP = 1, P_FEED = 2, P_DWELL = 3;
    localparam int P_RETRACT = 4, P_SPINDOWN = 5, P_FAULT = 6;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic ena = 1'b0, start = 1'b0, stop = 1'b0, estop = 1'b0;
    logic fault_clr = 1'b0, lim_fwd = 1'b0, lim_home = 1'b0;
    logic spindle_on, coolant_on, feed_fwd, feed_rev, busy, done, fault;
    logic [2:0] fault_code, state;

    always #5 clk = ~clk;

    lathe_cycle_sequencer #(
        .SETTLE_CYCLES  (SETTLE),
        .DWELL_CYCLES   (DWELL),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .i_ena        (ena),
        .i_start      (start),
        .i_stop       (stop),
        .i_estop      (estop),
        .i_fault_clr  (fault_clr),
        .i_lim_fwd    (lim_fwd),
        .i_lim_home   (lim_home),
        .o_spindle_on (spindle_on),
        .o_coolant_on (coolant_on),
        .o_feed_fwd   (feed_fwd),
        .o_feed_rev   (feed_rev),
        .o_busy       (busy),
        .o_done       (done),
        .o_fault      (fault),
        .o_fault_code (fault_code),
        .o_state      (state)
    );

    logic [12:0] exp_q[$];
    int vectors = 0;
    int miscompares = 0;

    // reference model: current phase, enabled cycles spent in it so far
    int m_ph, m_el, m_code;
    bit m_abort, m_prev_start, m_done;

    function automatic int dur(input int ph);
        case (ph)
            P_SPINUP, P_SPINDOWN: return SETTLE;
            P_DWELL:              return DWELL;
            P_FEED, P_RETRACT:    return TMO;
            default:              return 0;
        endcase
    endfunction

    task automatic model_reset();
        m_ph = P_IDLE; m_el = 0; m_code = 0;
        m_abort = 0; m_prev_start = 0; m_done = 0;
    endtask

    task automatic enter(input int ph);
        m_ph = ph;
        m_el = 0;
    endtask

    // advance one clock edge using the inputs held during the past cycle
    task automatic model_step();
        bit edge_s, timeup;
        m_done = 0;
        edge_s = start && !m_prev_start;
        timeup = (m_el + 1 == dur(m_ph));
        if (estop) begin
            enter(P_FAULT);
            m_code = 4;
        end else if (ena) begin
            case (m_ph)
                P_IDLE:
                    if (edge_s) begin
                        if (lim_home) enter(P_SPINUP);
                        else begin enter(P_FAULT); m_code = 1; end
                    end
                P_SPINUP, P_DWELL:
                    if (stop) begin m_abort = 1; enter(P_RETRACT); end
                    else if (timeup) enter(m_ph == P_SPINUP ? P_FEED : P_RETRACT);
                    else m_el++;
                P_FEED:
                    if (stop) begin m_abort = 1; enter(P_RETRACT); end
                    else if (lim_fwd) enter(P_DWELL);
                    else if (timeup) begin enter(P_FAULT); m_code = 2; end
                    else m_el++;
                P_RETRACT:
                    if (lim_home) enter(P_SPINDOWN);
                    else if (timeup) begin enter(P_FAULT); m_code = 3; end
                    else m_el++;
                P_SPINDOWN:
                    if (timeup) begin m_done = !m_abort; m_abort = 0; enter(P_IDLE); end
                    else m_el++;
                P_FAULT:
                    if (fault_clr) begin enter(P_IDLE); m_code = 0; m_abort = 0; end
                default: enter(P_IDLE);
            endcase
        end
        if (ena) m_prev_start = start;
    endtask

    // {spindle, coolant, fwd, rev, busy, done, fault, code, state}
    function automatic logic [12:0] exp_vec();
        bit run, active;
        run    = (m_ph >= P_SPINUP) && (m_ph <= P_RETRACT);
        active = (m_ph >= P_SPINUP) && (m_ph <= P_SPINDOWN);
        return {run && !estop, active, (m_ph == P_FEED) && !estop,
                (m_ph == P_RETRACT) && !estop, active, m_done,
                m_ph == P_FAULT, 3'(m_code), 3'(m_ph)};
    endfunction

    // monitor: compare DUT outputs against the oldest prediction
    always @(negedge clk) begin
        logic [12:0] e, got;
        if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            got = {spindle_on, coolant_on, feed_fwd, feed_rev, busy, done,
                   fault, fault_code, state};
            vectors++;
            if (got !== e) begin
                miscompares++;
                $display("FAIL outputs t=%0t got=%b expected=%b (sp,cl,fw,rv,bz,dn,ft,code,st)",
                         $time, got, e);
            end
        end
    end

    int es_left = 0;
    int fz_left = 0;

    // drive new inputs shortly after the edge; plant follows the model phase
    task automatic drive_inputs(input int i);
        reset = (i < 3) || ($urandom_range(0, 599) == 0);
        if (es_left > 0) es_left--;
        else if ($urandom_range(0, 299) == 0) es_left = $urandom_range(1, 4);
        estop = (es_left > 0);
        if (fz_left > 0) fz_left--;
        else if ($urandom_range(0, 399) == 0) fz_left = 10;
        ena = (fz_left == 0) && ($urandom_range(0, 11) != 0);
        if ($urandom_range(0, 3) == 0) start = ~start;
        stop      = ($urandom_range(0, 59) == 0);
        fault_clr = ($urandom_range(0, 5) == 0);
        lim_fwd   = (m_ph == P_FEED) ? ($urandom_range(0, 7) == 0)
                                     : ($urandom_range(0, 49) == 0);
        case (m_ph)
            P_FEED, P_DWELL: lim_home = 1'b0;
            P_RETRACT:       lim_home = ($urandom_range(0, 5) == 0);
            default:         lim_home = ($urandom_range(0, 9) != 0);
        endcase
    endtask

    initial begin
        model_reset();
        for (int i = 0; i < NCYC; i++) begin
            @(posedge clk);
            if (reset) model_reset();
            else       model_step();
            #1;
            drive_inputs(i);
            // reset acts asynchronously: outputs must clear within this cycle
            if (reset) model_reset();
            exp_q.push_back(exp_vec());
        end
        @(posedge clk);
        @(posedge clk);
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain pending=%0d expected=0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
